// File: rtl/tl45_pkg.sv
// ---------------------------------------------------------------------------
// tl45_pkg : shared types for the tl45 load/store unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tl45_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STROBE   = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_RESP     = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_MISALIGN = 2'd1,
        CAUSE_BUS_ERR  = 2'd2,
        CAUSE_TIMEOUT  = 2'd3
    } lsu_cause_t;

    // A doubleword on a 32-bit bus cannot be issued, so it traps like a misalignment.
    function automatic logic is_misaligned(input lsu_size_t size, input logic [2:0] off,
                                           input logic dword_ok);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return |off[1:0];
            default: return (|off) || !dword_ok;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/tl45_lsu_lanes.sv
// ---------------------------------------------------------------------------
// tl45_lsu_lanes : big-endian byte-lane steering (sel, store shift, load extend)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tl45_lsu_lanes
    import tl45_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SEL_W  = DATA_W / 8,
    parameter int OFF_W  = $clog2(SEL_W)
) (
    input  lsu_size_t         i_size,
    input  logic [OFF_W-1:0]  i_off,
    input  logic              i_signed,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [SEL_W-1:0]  o_sel,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    int                nb;
    int                sh;
    logic [SEL_W-1:0]  bmask;
    logic [DATA_W-1:0] dmask;
    logic [DATA_W-1:0] rsh;
    logic [DATA_W-1:0] rraw;
    logic              sbit;

    // Offset 0 is the MSB lane, so the shift counts lanes below the access.
    always_comb begin
        nb = 1 << int'(i_size);
        if (nb > SEL_W) nb = SEL_W;
        sh = SEL_W - int'(i_off) - nb;
        if (sh < 0) sh = 0;
        bmask = '0;
        dmask = '0;
        sbit  = 1'b0;
        rsh   = i_rdata >> (sh * 8);
        for (int i = 0; i < SEL_W; i++) begin
            if (i < nb) begin
                bmask[i]       = 1'b1;
                dmask[i*8 +: 8] = 8'hFF;
            end
            if (i == nb - 1) sbit = rsh[i*8 + 7];
        end
        rraw    = rsh & dmask;
        o_sel   = bmask << sh;
        o_wdata = (i_wdata & dmask) << (sh * 8);
        o_rdata = (i_signed && sbit) ? (rraw | ~dmask) : rraw;
    end

endmodule

`default_nettype wire

// File: rtl/tl45_lsu.sv
// ---------------------------------------------------------------------------
// tl45_lsu : single-outstanding Wishbone B4 pipelined load/store unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tl45_lsu
    import tl45_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int BADDR_W = 32,
    parameter int DR_W    = 4,
    parameter int TIMEOUT = 255,
    parameter int SEL_W   = DATA_W / 8,
    parameter int OFF_W   = $clog2(SEL_W)
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_pipe_stall,
    input  logic                     i_pipe_flush,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic                     i_req_we,
    input  logic [1:0]               i_req_size,
    input  logic                     i_req_signed,
    input  logic [BADDR_W-1:0]       i_req_addr,
    input  logic [DATA_W-1:0]        i_req_wdata,
    input  logic [DR_W-1:0]          i_req_dr,
    output logic                     o_wb_cyc,
    output logic                     o_wb_stb,
    output logic                     o_wb_we,
    output logic [BADDR_W-OFF_W-1:0] o_wb_addr,
    output logic [DATA_W-1:0]        o_wb_data,
    output logic [SEL_W-1:0]         o_wb_sel,
    input  logic                     i_wb_ack,
    input  logic                     i_wb_stall,
    input  logic                     i_wb_err,
    input  logic [DATA_W-1:0]        i_wb_data,
    output logic                     o_rsp_valid,
    output logic [DR_W-1:0]          o_rsp_dr,
    output logic [DATA_W-1:0]        o_rsp_data,
    output logic                     o_rsp_err,
    output logic [1:0]               o_rsp_cause,
    output logic [DR_W-1:0]          o_fwd_dr,
    output logic [DATA_W-1:0]        o_fwd_val
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    lsu_state_t               state_q, state_d;
    logic                     we_q, we_d;
    lsu_size_t                size_q, size_d;
    logic                     sgn_q, sgn_d;
    logic [BADDR_W-OFF_W-1:0] waddr_q, waddr_d;
    logic [OFF_W-1:0]         off_q, off_d;
    logic [DATA_W-1:0]        wdata_q, wdata_d;
    logic [DR_W-1:0]          dr_q, dr_d;
    logic [TMR_W-1:0]         timer_q, timer_d;
    logic [DATA_W-1:0]        rsp_data_q, rsp_data_d;
    logic [DR_W-1:0]          rsp_dr_q, rsp_dr_d;
    logic                     rsp_err_q, rsp_err_d;
    lsu_cause_t               rsp_cause_q, rsp_cause_d;

    logic [SEL_W-1:0]         lane_sel;
    logic [DATA_W-1:0]        lane_wdata;
    logic [DATA_W-1:0]        lane_rdata;
    logic                     bus_cyc;
    logic                     tmo_hit;

    tl45_lsu_lanes #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W),
        .OFF_W  (OFF_W)
    ) u_lanes (
        .i_size   (size_q),
        .i_off    (off_q),
        .i_signed (sgn_q),
        .i_wdata  (wdata_q),
        .i_rdata  (i_wb_data),
        .o_sel    (lane_sel),
        .o_wdata  (lane_wdata),
        .o_rdata  (lane_rdata)
    );

    assign tmo_hit = (TIMEOUT != 0) && (timer_q == TMR_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        waddr_d     = waddr_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        dr_d        = dr_q;
        timer_d     = '0;
        rsp_data_d  = rsp_data_q;
        rsp_dr_d    = rsp_dr_q;
        rsp_err_d   = rsp_err_q;
        rsp_cause_d = rsp_cause_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req_valid && !i_pipe_flush) begin
                    we_d        = i_req_we;
                    size_d      = lsu_size_t'(i_req_size);
                    sgn_d       = i_req_signed;
                    waddr_d     = i_req_addr[BADDR_W-1:OFF_W];
                    off_d       = i_req_addr[OFF_W-1:0];
                    wdata_d     = i_req_wdata;
                    dr_d        = i_req_we ? '0 : i_req_dr;
                    rsp_data_d  = '0;
                    rsp_dr_d    = '0;
                    rsp_err_d   = 1'b0;
                    rsp_cause_d = CAUSE_NONE;
                    if (is_misaligned(lsu_size_t'(i_req_size), i_req_addr[2:0], DATA_W == 64)) begin
                        rsp_err_d   = 1'b1;
                        rsp_cause_d = CAUSE_MISALIGN;
                        state_d     = ST_RESP;
                    end else begin
                        state_d = ST_STROBE;
                    end
                end
            end
            ST_STROBE, ST_WAIT_ACK: begin
                // Priority: flush, then bus error, then ack, then timeout.
                if (i_pipe_flush) begin
                    state_d = ST_IDLE;
                end else if (i_wb_err) begin
                    rsp_err_d   = 1'b1;
                    rsp_cause_d = CAUSE_BUS_ERR;
                    state_d     = ST_RESP;
                end else if (i_wb_ack) begin
                    rsp_data_d = we_q ? '0 : lane_rdata;
                    rsp_dr_d   = dr_q;
                    state_d    = ST_RESP;
                end else if (tmo_hit) begin
                    rsp_err_d   = 1'b1;
                    rsp_cause_d = CAUSE_TIMEOUT;
                    state_d     = ST_RESP;
                end else begin
                    timer_d = (TIMEOUT != 0) ? timer_q + 1'b1 : '0;
                    if (state_q == ST_STROBE && !i_wb_stall) state_d = ST_WAIT_ACK;
                end
            end
            ST_RESP: begin
                if (i_pipe_flush || !i_pipe_stall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            size_q      <= SZ_B;
            sgn_q       <= 1'b0;
            waddr_q     <= '0;
            off_q       <= '0;
            wdata_q     <= '0;
            dr_q        <= '0;
            timer_q     <= '0;
            rsp_data_q  <= '0;
            rsp_dr_q    <= '0;
            rsp_err_q   <= 1'b0;
            rsp_cause_q <= CAUSE_NONE;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            waddr_q     <= waddr_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            dr_q        <= dr_d;
            timer_q     <= timer_d;
            rsp_data_q  <= rsp_data_d;
            rsp_dr_q    <= rsp_dr_d;
            rsp_err_q   <= rsp_err_d;
            rsp_cause_q <= rsp_cause_d;
        end
    end

    // Bus strobes decode straight from state so reset and abort drop them at once.
    assign bus_cyc     = (state_q == ST_STROBE) || (state_q == ST_WAIT_ACK);
    assign o_wb_cyc    = bus_cyc;
    assign o_wb_stb    = (state_q == ST_STROBE);
    assign o_wb_we     = bus_cyc && we_q;
    assign o_wb_addr   = waddr_q;
    assign o_wb_sel    = bus_cyc ? lane_sel : '0;
    assign o_wb_data   = bus_cyc ? lane_wdata : '0;

    assign o_req_ready = (state_q == ST_IDLE) && !i_pipe_flush;
    assign o_rsp_valid = (state_q == ST_RESP) && !i_pipe_flush;
    assign o_rsp_dr    = o_rsp_valid ? rsp_dr_q : '0;
    assign o_rsp_data  = o_rsp_valid ? rsp_data_q : '0;
    assign o_rsp_err   = o_rsp_valid && rsp_err_q;
    assign o_rsp_cause = o_rsp_valid ? rsp_cause_q : CAUSE_NONE;
    assign o_fwd_dr    = (o_rsp_valid && !rsp_err_q) ? rsp_dr_q : '0;
    assign o_fwd_val   = (o_rsp_valid && !rsp_err_q) ? rsp_data_q : '0;

endmodule

`default_nettype wire
